axi_lite_mem_bridge_v2: RTL and testbench
=========================================

Name: axi_lite_mem_bridge_v2

Overview:
AXI4-Lite slave to simple memory-port bridge. It is the parametrised successor of the current AXI-lite/memory bridge.
- AW and W channels are accepted independently, each into its own one-entry buffer.
- Reads and writes to the single memory are arbitrated round-robin.
- Out-of-range and misaligned accesses get error responses and never reach memory.
- A memory-response timeout is enforced.
Sits between the core/bus AXI-lite master and the memory model or controller.

Parameters:
DATA_WIDTH, 64, data bus width in bits; power of two, >=32.
ADDR_WIDTH, 64, address width in bits.
BASE_ADDR, 0, first byte address decoded to memory.
ADDR_SPAN, 64'h10000, decoded region size in bytes.
TIMEOUT_CYCLES, 256, max cycles waiting for mem valid; 0 disables the timeout.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid / s_awready  in / out  1  AW handshake
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte strobes
s_wvalid / s_wready  in / out  1  W handshake
s_bresp  out  2  write response
s_bvalid / s_bready  out / in  1  B handshake
s_araddr  in  ADDR_WIDTH  read address
s_arvalid / s_arready  in / out  1  AR handshake
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid / s_rready  out / in  1  R handshake
mem_waddr / mem_wdata / mem_wmask  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  memory write request
mem_wen  out  1  write enable, held until completion
mem_wvalid  in  1  write done
mem_raddr  out  ADDR_WIDTH  memory read address
mem_ren  out  1  read enable, held until completion
mem_rdata  in  DATA_WIDTH  read data
mem_rvalid  in  1  read data valid

Behaviour:
- Reset: asynchronous on rstn low. All outputs 0: readies, valids, resps, rdata, mem_* enables and buses. FSM goes to IDLE, buffers empty, rr_last=read, timeout counter 0. Reset mid-access drops mem_wen/mem_ren immediately; the in-flight transaction is discarded with no response.
- AW buffer: s_awready = AW buffer empty. A handshake loads the address at the edge. W buffer: same rule using s_wready. The AW and W handshakes may occur in either order or in the same cycle.
- Write pending: both buffers full and bvalid=0. Read pending: AR buffer full (s_arready = AR buffer empty) and rvalid=0.
- FSM states:
  - IDLE: if only one request is pending, grant it. If both are pending, grant the type not equal to rr_last, then update rr_last.
  - On grant, check the address:
    - Misaligned (low log2(DATA_WIDTH/8) bits nonzero): resp SLVERR (2'b10).
    - Outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN): resp DECERR (2'b11). Compare in ADDR_WIDTH+1 bits so BASE+SPAN cannot wrap.
    - On either error: no mem access; B/R valid asserts next edge, rdata=0; free the buffers; stay in IDLE.
    - Otherwise assert mem_wen or mem_ren at the next edge; go to WR_MEM or RD_MEM. mem_waddr/raddr, wdata and wmask are driven from the buffers.
  - WR_MEM: mem_wen=1. On a cycle with mem_wvalid=1: next edge mem_wen=0, s_bvalid=1, s_bresp=OKAY, AW/W buffers freed, go to IDLE.
  - RD_MEM: mem_ren=1. On mem_rvalid=1: capture mem_rdata into s_rdata, s_rvalid=1, s_rresp=OKAY, mem_ren=0, AR buffer freed, go to IDLE.
  - Timeout (TIMEOUT_CYCLES>0): the counter increments each cycle in WR_MEM/RD_MEM. When it reaches TIMEOUT_CYCLES with no valid: drop the enable, respond SLVERR (rdata=0), return to IDLE. The counter clears on leaving either state.
- Response channels: s_bvalid/s_rvalid hold, with stable data, until ready; they clear at the handshake edge. A pending B does not block reads, and vice versa. The buffers re-open as soon as they are freed, so a new AW/W can be accepted while B is still pending.
- Minimum latency: handshake edge N; enable at N+1; if the memory valid is seen in cycle N+1, B/R valid at N+2.
- Only one memory access is in flight at a time. mem_wen and mem_ren are never both 1.

Test Plan:
- AW at cycle 0, W at cycle 3, addr 0x10, data 0xDEADBEEF_CAFEF00D, strb 0xFF, mem_wvalid 2 cycles after wen -> wen high 4 cycles total after W; bvalid with bresp 0; wmask 0xFF.
- Write and read pending in the same cycle after reset (rr_last=read) -> write granted first, read next; alternating thereafter under continuous load.
- Read at 0x10008 (BASE 0, SPAN 0x10000) -> rresp 2'b11, rdata 0, mem_ren never asserted. Read at 0x4 -> rresp 2'b10.
- mem_rvalid held 0, TIMEOUT_CYCLES=8 -> mem_ren drops after 8 cycles; rvalid with rresp 2'b10.
- rstn pulsed low during RD_MEM -> mem_ren=0 asynchronously, no R response; the next read completes normally.
- bready held low while a read is issued -> the read completes with R handshake while bvalid stays 1 with a stable bresp.

Source files
------------

// File: rtl/axi_lite_mem_bridge_v2.sv
// AXI4-Lite slave to single-port memory bridge.
// One-entry AW/W/AR buffers, round-robin R/W arbitration, error decode, timeout.
module axi_lite_mem_bridge_v2 #(
  parameter int unsigned             DATA_WIDTH     = 64,
  parameter int unsigned             ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0]   ADDR_SPAN      = 64'h10000,
  parameter int unsigned             TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic                    mem_wen,
  input  logic                    mem_wvalid,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  output logic                    mem_ren,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned TW     =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WR_MEM, RD_MEM} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_aw_full;
  logic                    r_w_full;
  logic                    r_ar_full;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rr_last_rd;
  logic [TW-1:0]           r_tcnt;

  logic                    w_wr_pend;
  logic                    w_rd_pend;
  logic                    w_sel_wr;
  logic [ADDR_WIDTH-1:0]   w_gaddr;
  logic [ADDR_WIDTH:0]     w_off;
  logic                    w_misal;
  logic                    w_oor;
  logic                    w_tmo;
  logic                    w_gnt;
  logic                    w_gnt_rd;
  logic                    w_b_set;
  logic [1:0]              w_b_resp;
  logic                    w_r_set;
  logic [1:0]              w_r_resp;
  logic                    w_r_ok;

  assign s_awready = rstn & ~r_aw_full;
  assign s_wready  = rstn & ~r_w_full;
  assign s_arready = rstn & ~r_ar_full;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;
  assign mem_waddr = r_awaddr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wstrb;
  assign mem_raddr = r_araddr;
  assign mem_wen   = (r_state == WR_MEM);
  assign mem_ren   = (r_state == RD_MEM);

  assign w_wr_pend = r_aw_full & r_w_full & ~r_bvalid;
  assign w_rd_pend = r_ar_full & ~r_rvalid;
  assign w_sel_wr  = w_wr_pend & (~w_rd_pend | r_rr_last_rd);
  assign w_gaddr   = w_sel_wr ? r_awaddr : r_araddr;
  assign w_misal   = |w_gaddr[LSB-1:0];
  assign w_off     = {1'b0, w_gaddr} - {1'b0, BASE_ADDR};
  assign w_oor     = w_off[ADDR_WIDTH] |
                     (w_off[ADDR_WIDTH-1:0] >= ADDR_SPAN);
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_tcnt == TLIM);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, address check, completion and timeout decisions
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_gnt_rd    = 1'b0;
    w_b_set     = 1'b0;
    w_b_resp    = 2'b00;
    w_r_set     = 1'b0;
    w_r_resp    = 2'b00;
    w_r_ok      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_wr_pend || w_rd_pend) begin
          w_gnt    = 1'b1;
          w_gnt_rd = ~w_sel_wr;
          if (w_misal || w_oor) begin
            w_b_set  = w_sel_wr;
            w_r_set  = ~w_sel_wr;
            w_b_resp = w_misal ? 2'b10 : 2'b11;
            w_r_resp = w_misal ? 2'b10 : 2'b11;
          end else begin
            w_state_nxt = w_sel_wr ? WR_MEM : RD_MEM;
          end
        end
      end
      WR_MEM: begin
        if (mem_wvalid) begin
          w_b_set     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_b_set     = 1'b1;
          w_b_resp    = 2'b10;
          w_state_nxt = IDLE;
        end
      end
      RD_MEM: begin
        if (mem_rvalid) begin
          w_r_set     = 1'b1;
          w_r_ok      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_r_set     = 1'b1;
          w_r_resp    = 2'b10;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request buffers: load on handshake, free when the response is raised
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (s_awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_awaddr;
      end else if (w_b_set) begin
        r_aw_full <= 1'b0;
      end
      if (s_wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end else if (w_b_set) begin
        r_w_full <= 1'b0;
      end
      if (s_arvalid && !r_ar_full) begin
        r_ar_full <= 1'b1;
        r_araddr  <= s_araddr;
      end else if (w_r_set) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  // Response channels hold until the master's handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
    end else begin
      if (w_b_set) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_b_resp;
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_r_set) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_r_resp;
        r_rdata  <= w_r_ok ? mem_rdata : '0;
      end else if (r_rvalid && s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Round-robin history and memory-wait counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_last_rd <= 1'b1;
      r_tcnt       <= '0;
    end else begin
      if (w_gnt) r_rr_last_rd <= w_gnt_rd;
      if (r_state != IDLE && w_state_nxt == r_state)
        r_tcnt <= r_tcnt + 1'b1;
      else
        r_tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_bridge_v2.sv
// Directed testbench for axi_lite_mem_bridge_v2.
// Linear stimulus with immediate-assertion checks.
module tb_axi_lite_mem_bridge_v2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [63:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen;
  logic        mem_wvalid;
  logic [63:0] mem_raddr;
  logic        mem_ren;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;

  int vec  = 0;
  int miss = 0;
  int n;

  always #5 clk = ~clk;

  axi_lite_mem_bridge_v2 #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen),
    .mem_wvalid(mem_wvalid), .mem_raddr(mem_raddr),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    mem_wvalid = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ren", mem_ren, 0);
    chk("rst_waddr", mem_waddr, 0);
    rstn = 1'b1;
    tick();
    chk("awready_open", s_awready, 1);

    // write: AW first, W three cycles later, memory done 2 cycles after wen
    s_awaddr = 64'h10; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    chk("aw_taken", s_awready, 0);
    tick(); tick();
    s_wdata = 64'hDEADBEEF_CAFEF00D; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("wen_n0", mem_wen, 0);
    tick();
    chk("wen_n1", mem_wen, 1);
    chk("waddr", mem_waddr, 64'h10);
    chk("wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("wmask", mem_wmask, 8'hFF);
    tick();
    chk("wen_n2", mem_wen, 1);
    tick();
    chk("wen_n3", mem_wen, 1);
    mem_wvalid = 1'b1;
    tick();
    mem_wvalid = 1'b0;
    chk("wen_n4", mem_wen, 0);
    chk("w1_bvalid", s_bvalid, 1);
    chk("w1_bresp", s_bresp, 0);
    chk("w1_awready", s_awready, 1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("w1_bclr", s_bvalid, 0);

    // round robin: both pending after reset -> write first
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    s_awaddr = 64'h20; s_awvalid = 1'b1;
    s_wdata = 64'h1111; s_wstrb = 8'h0F; s_wvalid = 1'b1;
    s_araddr = 64'h30; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    tick();
    chk("rr1_wen", mem_wen, 1);
    chk("rr1_ren", mem_ren, 0);
    mem_wvalid = 1'b1;
    tick();
    mem_wvalid = 1'b0;
    chk("rr1_bvalid", s_bvalid, 1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("rr1_ren2", mem_ren, 1);
    chk("rr1_wen2", mem_wen, 0);
    chk("rr1_raddr", mem_raddr, 64'h30);
    mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rr1_rvalid", s_rvalid, 1);
    chk("rr1_rdata", s_rdata, 64'h0123_4567_89AB_CDEF);
    chk("rr1_rresp", s_rresp, 0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // lone write makes write the last grant
    s_awaddr = 64'h40; s_awvalid = 1'b1;
    s_wdata = 64'h2222; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    chk("lone_wen", mem_wen, 1);
    mem_wvalid = 1'b1;
    tick();
    mem_wvalid = 1'b0;
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;

    // both pending again, last was write -> read first, then write
    s_awaddr = 64'h48; s_awvalid = 1'b1;
    s_wdata = 64'h3333; s_wvalid = 1'b1;
    s_araddr = 64'h38; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    tick();
    chk("rr2_ren", mem_ren, 1);
    chk("rr2_wen", mem_wen, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h55;
    tick();
    mem_rvalid = 1'b0;
    chk("rr2_rvalid", s_rvalid, 1);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk("rr2_wen2", mem_wen, 1);
    chk("rr2_waddr", mem_waddr, 64'h48);
    mem_wvalid = 1'b1;
    tick();
    mem_wvalid = 1'b0;
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;

    // out-of-range read -> DECERR, no memory access
    s_araddr = 64'h10008; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("dec_ren0", mem_ren, 0);
    tick();
    chk("dec_ren1", mem_ren, 0);
    chk("dec_rvalid", s_rvalid, 1);
    chk("dec_rresp", s_rresp, 2'b11);
    chk("dec_rdata", s_rdata, 0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // misaligned read -> SLVERR
    s_araddr = 64'h4; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("mis_ren", mem_ren, 0);
    chk("mis_rvalid", s_rvalid, 1);
    chk("mis_rresp", s_rresp, 2'b10);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // memory never answers -> timeout after 8 cycles
    s_araddr = 64'h100; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    n = 0;
    while (mem_ren && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 8);
    chk("tmo_rvalid", s_rvalid, 1);
    chk("tmo_rresp", s_rresp, 2'b10);
    chk("tmo_rdata", s_rdata, 0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // reset during RD_MEM drops ren at once, no response
    s_araddr = 64'h200; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("rst_mid_ren", mem_ren, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_ren", mem_ren, 0);
    tick();
    rstn = 1'b1;
    tick(); tick();
    chk("rst_no_rvalid", s_rvalid, 0);
    chk("rst_arready", s_arready, 1);
    s_araddr = 64'h208; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("post_rst_raddr", mem_raddr, 64'h208);
    mem_rvalid = 1'b1; mem_rdata = 64'hA5A5;
    tick();
    mem_rvalid = 1'b0;
    chk("post_rst_rvalid", s_rvalid, 1);
    chk("post_rst_rdata", s_rdata, 64'hA5A5);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // pending B (DECERR write) does not block a read
    s_awaddr = 64'h20000; s_awvalid = 1'b1;
    s_wdata = 64'h77; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("werr_wen", mem_wen, 0);
    tick();
    chk("werr_bvalid", s_bvalid, 1);
    chk("werr_bresp", s_bresp, 2'b11);
    chk("werr_awready", s_awready, 1);
    s_araddr = 64'h58; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("bhold_ren", mem_ren, 1);
    mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("bhold_rdata", s_rdata, 64'hBEEF);
    chk("bhold_bvalid", s_bvalid, 1);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk("bhold_rclr", s_rvalid, 0);
    chk("bhold_bvalid2", s_bvalid, 1);
    chk("bhold_bresp2", s_bresp, 2'b11);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("bhold_bclr", s_bvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
